alu_op_decoder: RTL and testbench

- Pipelined decoder that turns a fetched MIPS instruction's opcode, funct and shamt into the 4-bit ALU operation code, operand-B source select and shift amount that drive the datapath ALU.
- Sits between instruction fetch and the ALU/operand muxes.
- Buffers decoded operations in a 2-entry queue with valid/ready handshakes on both sides, so fetch and execute can stall independently.
- Flags unsupported encodings instead of silently issuing an operation.

---
 rtl/mips_alu_pkg.sv | 61 ++++++
 rtl/alu_op_queue.sv | 57 +++++
 rtl/alu_op_decoder.sv | 118 +++++++++++
 tb/tb_alu_op_decoder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// Shared MIPS ALU definitions: operation codes, opcode/funct encodings
// and the decoded-op bundle used by the decoder and the ALU.
package mips_alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLLV = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRLV = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRAV = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLL  = 4'b1110;
    localparam logic [3:0] ALU_SRL  = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    typedef struct packed {
        logic [3:0] alu_control;
        logic       alu_src_imm;
        logic [4:0] shamt;
        logic       illegal;
    } dec_op_t;

    localparam int DEC_OP_W = $bits(dec_op_t);

endpackage

// File: rtl/alu_op_queue.sv
// Two-entry valid/ready buffer; 1-bit read/write pointers and a 2-bit count.
module alu_op_queue
    import mips_alu_pkg::*;
#(
    parameter int W = DEC_OP_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;
    logic         sel;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // When drained, keep showing the entry that was last at the head.
    assign sel      = (count == 2'd0) ? ~rd_ptr : rd_ptr;
    assign out_data = mem[sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_decoder.sv
// MIPS opcode/funct -> ALU op decoder feeding a 2-entry handshake queue.
// Optional illegal-encoding counter enabled by ALU_DEC_STATS_EN.
module alu_op_decoder
    import mips_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_control,
    output logic        alu_src_imm,
    output logic [4:0]  shamt,
    output logic        illegal
`ifdef ALU_DEC_STATS_EN
    ,
    output logic [15:0] illegal_count
`endif
);

    logic [5:0] opcode;
    logic [5:0] funct;
    dec_op_t    dec;
    dec_op_t    head;
    logic       push;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign push   = in_valid & in_ready;

    always_comb begin
        dec             = '0;
        dec.shamt       = instr[10:6];
        dec.alu_src_imm = 1'b1;
        unique case (opcode)
            OP_RTYPE: begin
                dec.alu_src_imm = 1'b0;
                unique case (funct)
                    FN_ADD,
                    FN_ADDU: dec.alu_control = ALU_ADD;
                    FN_SUB,
                    FN_SUBU: dec.alu_control = ALU_SUB;
                    FN_AND:  dec.alu_control = ALU_AND;
                    FN_OR:   dec.alu_control = ALU_OR;
                    FN_XOR:  dec.alu_control = ALU_XOR;
                    FN_NOR:  dec.alu_control = ALU_NOR;
                    FN_SLT:  dec.alu_control = ALU_SLT;
                    FN_SLTU: dec.alu_control = ALU_SLTU;
                    FN_SLL:  dec.alu_control = ALU_SLL;
                    FN_SRL:  dec.alu_control = ALU_SRL;
                    FN_SRA:  dec.alu_control = ALU_SRA;
                    FN_SLLV: dec.alu_control = ALU_SLLV;
                    FN_SRLV: dec.alu_control = ALU_SRLV;
                    FN_SRAV: dec.alu_control = ALU_SRAV;
                    default: dec.illegal     = 1'b1;
                endcase
            end
            OP_ADDI,
            OP_ADDIU,
            OP_LW,
            OP_SW:    dec.alu_control = ALU_ADD;
            OP_ANDI:  dec.alu_control = ALU_AND;
            OP_ORI:   dec.alu_control = ALU_OR;
            OP_XORI:  dec.alu_control = ALU_XOR;
            OP_SLTI:  dec.alu_control = ALU_SLT;
            OP_SLTIU: dec.alu_control = ALU_SLTU;
            OP_LUI:   dec.alu_control = ALU_LUI;
            OP_BEQ,
            OP_BNE: begin
                dec.alu_control = ALU_SUB;
                dec.alu_src_imm = 1'b0;
            end
            default: begin
                dec.alu_src_imm = 1'b0;
                dec.illegal     = 1'b1;
            end
        endcase
        // Unsupported encodings never issue a real operation.
        if (dec.illegal) begin
            dec.alu_control = ALU_AND;
            dec.alu_src_imm = 1'b0;
        end
    end

    alu_op_queue #(
        .W (DEC_OP_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign alu_control = head.alu_control;
    assign alu_src_imm = head.alu_src_imm;
    assign shamt       = head.shamt;
    assign illegal     = head.illegal;

`ifdef ALU_DEC_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_count <= 16'd0;
        end else if (push && dec.illegal && illegal_count != 16'hFFFF) begin
            illegal_count <= illegal_count + 16'd1;
        end
    end
`else
    logic unused_push;
    assign unused_push = push;
`endif

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed-vector bench for alu_op_decoder.
// Build with ALU_DEC_STATS_EN defined to also cover illegal_count.
module tb_alu_op_decoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_control;
    logic        alu_src_imm;
    logic [4:0]  shamt;
    logic        illegal;
`ifdef ALU_DEC_STATS_EN
    logic [15:0] illegal_count;
`endif

    int vecs;
    int errs;

    alu_op_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .alu_src_imm (alu_src_imm),
        .shamt       (shamt),
        .illegal     (illegal)
`ifdef ALU_DEC_STATS_EN
        ,
        .illegal_count (illegal_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {out_valid, alu_control, alu_src_imm, shamt, illegal}
    function automatic logic [11:0] obs();
        return {out_valid, alu_control, alu_src_imm, shamt, illegal};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
        step();
        step();
        rst = 1'b0;
        vecs++;
        if (obs() !== 12'h000) begin
            $display("FAIL reset_fields got=%h exp=%h", obs(), 12'h000);
            errs++;
        end
        vecs++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
            errs++;
        end
`ifdef ALU_DEC_STATS_EN
        vecs++;
        if (illegal_count !== 16'd0) begin
            $display("FAIL reset_illegal_count got=%0d exp=0", illegal_count);
            errs++;
        end
`endif
    endtask

    task automatic test_add();
        logic [11:0] exp;
        out_ready = 1'b1;
        in_valid = 1'b1; instr = 32'h012A4020;
        step();
        in_valid = 1'b0;
        exp = {1'b1, 4'b0010, 1'b0, 5'd0, 1'b0};
        vecs++;
        if (obs() !== exp) begin
            $display("FAIL add got=%h exp=%h", obs(), exp);
            errs++;
        end
        step();
        vecs++;
        if (out_valid !== 1'b0) begin
            $display("FAIL add_drain got=%b exp=0", out_valid);
            errs++;
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp;
        out_ready = 1'b1;
        in_valid = 1'b1; instr = 32'h00094083;
        step();
        exp = {1'b1, 4'b1011, 1'b0, 5'd2, 1'b0};
        vecs++;
        if (obs() !== exp || in_ready !== 1'b1) begin
            $display("FAIL b2b_sra got=%h rdy=%b exp=%h rdy=1", obs(), in_ready, exp);
            errs++;
        end
        instr = 32'h3C011234;
        step();
        in_valid = 1'b0;
        exp = {1'b1, 4'b1010, 1'b1, 5'd8, 1'b0};
        vecs++;
        if (obs() !== exp || in_ready !== 1'b1) begin
            $display("FAIL b2b_lui got=%h rdy=%b exp=%h rdy=1", obs(), in_ready, exp);
            errs++;
        end
        step();
        vecs++;
        if (out_valid !== 1'b0) begin
            $display("FAIL b2b_drain got=%b exp=0", out_valid);
            errs++;
        end
    endtask

    task automatic test_stall();
        logic [11:0] e_ori;
        logic [11:0] e_sw;
        logic [11:0] e_nor;
        e_ori = {1'b1, 4'b0001, 1'b1, 5'd1, 1'b0};
        e_sw  = {1'b1, 4'b0010, 1'b1, 5'd0, 1'b0};
        e_nor = {1'b1, 4'b1100, 1'b0, 5'd0, 1'b0};
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h34A50041;
        step();
        vecs++;
        if (obs() !== e_ori || in_ready !== 1'b1) begin
            $display("FAIL stall_first got=%h rdy=%b exp=%h rdy=1", obs(), in_ready, e_ori);
            errs++;
        end
        instr = 32'hAC000000;
        step();
        vecs++;
        if (obs() !== e_ori || in_ready !== 1'b0) begin
            $display("FAIL stall_full got=%h rdy=%b exp=%h rdy=0", obs(), in_ready, e_ori);
            errs++;
        end
        instr = 32'h00000027;
        step();
        vecs++;
        if (obs() !== e_ori || in_ready !== 1'b0) begin
            $display("FAIL stall_hold got=%h rdy=%b exp=%h rdy=0", obs(), in_ready, e_ori);
            errs++;
        end
        out_ready = 1'b1;
        step();
        vecs++;
        if (obs() !== e_sw || in_ready !== 1'b1) begin
            $display("FAIL stall_pop2 got=%h rdy=%b exp=%h rdy=1", obs(), in_ready, e_sw);
            errs++;
        end
        step();
        in_valid = 1'b0;
        vecs++;
        if (obs() !== e_nor) begin
            $display("FAIL stall_pop3 got=%h exp=%h", obs(), e_nor);
            errs++;
        end
        step();
        vecs++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL stall_drain got=%b rdy=%b exp=0 rdy=1", out_valid, in_ready);
            errs++;
        end
    endtask

    task automatic test_illegal();
        logic [11:0] exp;
        exp = {1'b1, 4'b0000, 1'b0, 5'd0, 1'b1};
        out_ready = 1'b1;
        in_valid = 1'b1; instr = 32'hFC000000;
        step();
        vecs++;
        if (obs() !== exp) begin
            $display("FAIL illegal_opcode got=%h exp=%h", obs(), exp);
            errs++;
        end
        instr = 32'h0000000F;
        step();
        in_valid = 1'b0;
        vecs++;
        if (obs() !== exp) begin
            $display("FAIL illegal_funct got=%h exp=%h", obs(), exp);
            errs++;
        end
`ifdef ALU_DEC_STATS_EN
        vecs++;
        if (illegal_count !== 16'd2) begin
            $display("FAIL illegal_count got=%0d exp=2", illegal_count);
            errs++;
        end
`endif
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'hFC000000;
        step();
        step();
        vecs++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            $display("FAIL rstmid_full rdy=%b vld=%b exp rdy=0 vld=1", in_ready, out_valid);
            errs++;
        end
        rst = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        vecs++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL rstmid_state vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
            errs++;
        end
        vecs++;
        if (obs() !== 12'h000) begin
            $display("FAIL rstmid_fields got=%h exp=%h", obs(), 12'h000);
            errs++;
        end
`ifdef ALU_DEC_STATS_EN
        vecs++;
        if (illegal_count !== 16'd0) begin
            $display("FAIL rstmid_count got=%0d exp=0", illegal_count);
            errs++;
        end
`endif
    endtask

    task automatic test_branch();
        logic [11:0] exp;
        exp = {1'b1, 4'b0110, 1'b0, 5'd0, 1'b0};
        out_ready = 1'b1;
        in_valid = 1'b1; instr = 32'h11090003;
        step();
        in_valid = 1'b0;
        vecs++;
        if (obs() !== exp) begin
            $display("FAIL beq got=%h exp=%h", obs(), exp);
            errs++;
        end
        step();
    endtask

    task automatic test_rtype_mix();
        logic [31:0] ins [4];
        logic [11:0] exp [4];
        ins[0] = 32'h00000006; exp[0] = {1'b1, 4'b0101, 1'b0, 5'd0, 1'b0};
        ins[1] = 32'h000007C0; exp[1] = {1'b1, 4'b1110, 1'b0, 5'd31, 1'b0};
        ins[2] = 32'h0000002B; exp[2] = {1'b1, 4'b1001, 1'b0, 5'd0, 1'b0};
        ins[3] = 32'h2C000080; exp[3] = {1'b1, 4'b1001, 1'b1, 5'd2, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; instr = ins[i];
            step();
            vecs++;
            if (obs() !== exp[i]) begin
                $display("FAIL mix%0d got=%h exp=%h", i, obs(), exp[i]);
                errs++;
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_add();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_reset_mid();
        test_branch();
        test_rtype_mix();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
